// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module  : systolic_pkg
// Purpose : Shared types and helpers for the systolic array sequencing
//           logic: controller state encoding, default array geometry and the
//           flush-length helper used by the controller.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package systolic_pkg;

  // Default geometry shared by the controller, skew buffers and PE grid.
  localparam int DEFAULT_ARRAY_SIZE = 8;
  localparam int DEFAULT_K_WIDTH    = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD   = 3'd2,
    FLUSH  = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  // Zero-feed cycles needed to drain an N x N array: skew delay (N-1),
  // propagation across the grid (N-1) and the PE output register (1).
  function automatic int flush_cycles(input int n);
    return 2 * n - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : systolic_seq_ctrl
// Purpose : Sequences one matrix-multiply tile through the systolic array:
//           clears the PE accumulators, streams K operand vectors through the
//           skew buffers, flushes the array with zeros and hands the result
//           rows out over a valid/ready handshake.
// Ports   : clk, rst      - clock, asynchronous active-high reset
//           start, k_len  - command strobe and inner dimension K
//           abort         - synchronous cancel back to IDLE
//           busy          - high whenever not IDLE
//           acc_clear     - one-cycle PE accumulator clear
//           skew_en       - skew buffer / PE register enable
//           feed_zero     - operand muxes select zero
//           feed_idx      - operand read index k during LOAD
//           out_valid, out_row, out_ready - result row handshake
//           done          - one-cycle pulse after the final row handshake
// Revision: 1.0 - initial release
// ============================================================================
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
  parameter int K_WIDTH    = DEFAULT_K_WIDTH,
  parameter int ROW_IDX_W  = $clog2(ARRAY_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [K_WIDTH-1:0]   k_len,
  input  logic                 abort,
  output logic                 busy,
  output logic                 acc_clear,
  output logic                 skew_en,
  output logic                 feed_zero,
  output logic [K_WIDTH-1:0]   feed_idx,
  output logic                 out_valid,
  output logic [ROW_IDX_W-1:0] out_row,
  input  logic                 out_ready,
  output logic                 done
);

  localparam int C_FLUSH_CYCLES = flush_cycles(ARRAY_SIZE);
  localparam int C_FLUSH_W      = $clog2(C_FLUSH_CYCLES + 1);
  localparam logic [C_FLUSH_W-1:0] C_FLUSH_LAST = C_FLUSH_W'(C_FLUSH_CYCLES - 1);
  localparam logic [ROW_IDX_W-1:0] C_ROW_LAST   = ROW_IDX_W'(ARRAY_SIZE - 1);

  state_t                 r_state;
  logic [K_WIDTH-1:0]     r_k_len;
  logic [K_WIDTH-1:0]     r_k_cnt;
  logic [C_FLUSH_W-1:0]   r_flush_cnt;
  logic [ROW_IDX_W-1:0]   r_row_cnt;

  // Outputs are computed for the state being entered so that every output
  // is a flop aligned with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_k_len     <= '0;
      r_k_cnt     <= '0;
      r_flush_cnt <= '0;
      r_row_cnt   <= '0;
      busy        <= 1'b0;
      acc_clear   <= 1'b0;
      skew_en     <= 1'b0;
      feed_zero   <= 1'b0;
      feed_idx    <= '0;
      out_valid   <= 1'b0;
      out_row     <= '0;
      done        <= 1'b0;
    end else if (abort) begin
      // Cancel wins over every transition, including a start in IDLE.
      r_state     <= IDLE;
      r_k_cnt     <= '0;
      r_flush_cnt <= '0;
      r_row_cnt   <= '0;
      busy        <= 1'b0;
      acc_clear   <= 1'b0;
      skew_en     <= 1'b0;
      feed_zero   <= 1'b0;
      feed_idx    <= '0;
      out_valid   <= 1'b0;
      out_row     <= '0;
      done        <= 1'b0;
    end else begin
      done      <= 1'b0;
      acc_clear <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_k_len   <= k_len;
            r_state   <= CLEAR;
            busy      <= 1'b1;
            acc_clear <= 1'b1;
            // Zero-fill the skew pipes while the accumulators clear.
            skew_en   <= 1'b1;
            feed_zero <= 1'b1;
          end
        end

        CLEAR: begin
          if (r_k_len == '0) begin
            // Nothing to accumulate: the cleared array already holds zeros.
            r_state   <= OUTPUT;
            skew_en   <= 1'b0;
            feed_zero <= 1'b0;
            out_valid <= 1'b1;
            out_row   <= '0;
            r_row_cnt <= '0;
          end else begin
            r_state   <= LOAD;
            feed_zero <= 1'b0;
            r_k_cnt   <= '0;
            feed_idx  <= '0;
          end
        end

        LOAD: begin
          // K >= 1 here, so K-1 cannot underflow and k never wraps.
          if (r_k_cnt == r_k_len - 1'b1) begin
            r_state     <= FLUSH;
            feed_zero   <= 1'b1;
            feed_idx    <= '0;
            r_flush_cnt <= '0;
          end else begin
            r_k_cnt  <= r_k_cnt + 1'b1;
            feed_idx <= r_k_cnt + 1'b1;
          end
        end

        FLUSH: begin
          if (r_flush_cnt == C_FLUSH_LAST) begin
            r_state   <= OUTPUT;
            skew_en   <= 1'b0;
            feed_zero <= 1'b0;
            out_valid <= 1'b1;
            out_row   <= '0;
            r_row_cnt <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end

        OUTPUT: begin
          // out_valid is always high here, so ready alone completes a row.
          if (out_ready) begin
            if (r_row_cnt == C_ROW_LAST) begin
              r_state   <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_row   <= '0;
              r_row_cnt <= '0;
              done      <= 1'b1;
            end else begin
              r_row_cnt <= r_row_cnt + 1'b1;
              out_row   <= r_row_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state   <= IDLE;
          busy      <= 1'b0;
          skew_en   <= 1'b0;
          feed_zero <= 1'b0;
          feed_idx  <= '0;
          out_valid <= 1'b0;
          out_row   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_systolic_seq_ctrl
// Purpose : Directed self-checking bench for systolic_seq_ctrl with a 4x4
//           array (7 flush cycles). Cycle 0 is the cycle start is driven;
//           outputs are sampled on the falling edge of each later cycle.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_systolic_seq_ctrl;

  localparam int N  = 4;
  localparam int KW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          abort;
  logic          busy;
  logic          acc_clear;
  logic          skew_en;
  logic          feed_zero;
  logic [KW-1:0] feed_idx;
  logic          out_valid;
  logic [1:0]    out_row;
  logic          out_ready;
  logic          done;

  logic [23:0]   obs;
  int            n_checks = 0;
  int            n_fail   = 0;

  systolic_seq_ctrl #(
    .ARRAY_SIZE (N),
    .K_WIDTH    (KW),
    .ROW_IDX_W  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .abort     (abort),
    .busy      (busy),
    .acc_clear (acc_clear),
    .skew_en   (skew_en),
    .feed_zero (feed_zero),
    .feed_idx  (feed_idx),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_ready (out_ready),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Observed output bundle: busy, acc_clear, skew_en, feed_zero, out_valid,
  // done, out_row[1:0], feed_idx[15:0].
  assign obs = {busy, acc_clear, skew_en, feed_zero, out_valid, done, out_row, feed_idx};

  function automatic logic [23:0] pk(int b, int a, int s, int z, int v, int d, int r, int i);
    return {1'(b), 1'(a), 1'(s), 1'(z), 1'(v), 1'(d), 2'(r), 16'(i)};
  endfunction

  // Hand-derived timeline for a run with out_ready held high:
  // CLEAR at 1, LOAD 2..K+1, FLUSH K+2..K+8, OUTPUT K+9..K+12, done at K+13.
  // K=0: CLEAR at 1, OUTPUT 2..5, done at 6.
  function automatic logic [23:0] exp_run(int c, int k);
    if (c == 1) return pk(1, 1, 1, 1, 0, 0, 0, 0);
    if (k == 0) begin
      if (c >= 2 && c <= 5) return pk(1, 0, 0, 0, 1, 0, c - 2, 0);
      if (c == 6) return pk(0, 0, 0, 0, 0, 1, 0, 0);
      return '0;
    end
    if (c >= 2 && c <= k + 1)     return pk(1, 0, 1, 0, 0, 0, 0, c - 2);
    if (c >= k + 2 && c <= k + 8) return pk(1, 0, 1, 1, 0, 0, 0, 0);
    if (c >= k + 9 && c <= k + 12) return pk(1, 0, 0, 0, 1, 0, c - k - 9, 0);
    if (c == k + 13) return pk(0, 0, 0, 0, 0, 1, 0, 0);
    return '0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, 24'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    start = 1'b1; k_len = 16'd3; out_ready = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (obs !== exp_run(c, 3)) begin
        n_fail++;
        $display("FAIL basic_k3 cycle %0d: got %h expected %h", c, obs, exp_run(c, 3));
      end
    end
  endtask

  task automatic test_backpressure();
    // Ready pattern 1,0,1,0,... from the first OUTPUT cycle (12).
    logic [1:0] exp_row [7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    logic [23:0] e;
    @(negedge clk);
    start = 1'b1; k_len = 16'd3; out_ready = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c <= 11)      e = exp_run(c, 3);
      else if (c <= 18) e = pk(1, 0, 0, 0, 1, 0, int'(exp_row[c - 12]), 0);
      else if (c == 19) e = pk(0, 0, 0, 0, 0, 1, 0, 0);
      else              e = '0;
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL backpressure cycle %0d: got %h expected %h", c, obs, e);
      end
      out_ready = (c < 12) || ((c % 2) == 0);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_k_zero();
    @(negedge clk);
    start = 1'b1; k_len = 16'd0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (obs !== exp_run(c, 0)) begin
        n_fail++;
        $display("FAIL k_zero cycle %0d: got %h expected %h", c, obs, exp_run(c, 0));
      end
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    start = 1'b1; k_len = 16'd3;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (obs !== exp_run(c, 3)) begin
        n_fail++;
        $display("FAIL abort_pre cycle %0d: got %h expected %h", c, obs, exp_run(c, 3));
      end
    end
    abort = 1'b1;                       // during FLUSH cycle 8
    @(negedge clk);                     // cycle 9: IDLE, no done
    abort = 1'b0;
    n_checks++;
    if (obs !== 24'h0) begin
      n_fail++;
      $display("FAIL abort_idle: got %h expected %h", obs, 24'h0);
    end
    start = 1'b1; k_len = 16'd3;        // clean restart at cycle 9
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (obs !== exp_run(c, 3)) begin
        n_fail++;
        $display("FAIL abort_restart cycle %0d: got %h expected %h", c, obs, exp_run(c, 3));
      end
    end
    // abort and start together in IDLE: start is dropped.
    start = 1'b1; abort = 1'b1; k_len = 16'd2;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      n_checks++;
      if (obs !== 24'h0) begin
        n_fail++;
        $display("FAIL abort_with_start cycle %0d: got %h expected %h", c, obs, 24'h0);
      end
    end
  endtask

  task automatic test_ignored_start();
    @(negedge clk);
    start = 1'b1; k_len = 16'd3;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_run(c, 3)) begin
        n_fail++;
        $display("FAIL ignored_start cycle %0d: got %h expected %h", c, obs, exp_run(c, 3));
      end
      start = (c == 3) || (c == 10);
      k_len = 16'd7;                    // must not be latched while busy
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; k_len = 16'd2;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (obs !== exp_run(c, 2)) begin
        n_fail++;
        $display("FAIL b2b_first cycle %0d: got %h expected %h", c, obs, exp_run(c, 2));
      end
    end
    start = 1'b1; k_len = 16'd1;        // start in the done cycle
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (obs !== exp_run(c, 1)) begin
        n_fail++;
        $display("FAIL b2b_second cycle %0d: got %h expected %h", c, obs, exp_run(c, 1));
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start = 1'b1; k_len = 16'd3;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (obs !== exp_run(c, 3)) begin
        n_fail++;
        $display("FAIL async_pre cycle %0d: got %h expected %h", c, obs, exp_run(c, 3));
      end
    end
    #2 rst = 1'b1;                      // mid LOAD, clock is low
    #1;
    n_checks++;
    if (obs !== 24'h0) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %h expected %h", obs, 24'h0);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== 24'h0) begin
      n_fail++;
      $display("FAIL async_reset_after: got %h expected %h", obs, 24'h0);
    end
    start = 1'b1; k_len = 16'd1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (obs !== exp_run(c, 1)) begin
        n_fail++;
        $display("FAIL async_rerun cycle %0d: got %h expected %h", c, obs, exp_run(c, 1));
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; k_len = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_k_zero();
    test_abort();
    test_ignored_start();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequences one matrix-multiply tile through the systolic array datapath: input skew buffers, PE grid and accumulator readout.
- Accepts a start command carrying an inner dimension K, then:
  - clears the PE accumulators,
  - streams K operand vectors through the skew buffers,
  - flushes the array with zeros,
  - hands results out row by row over a valid/ready handshake.
- Sits between the host or DMA command interface and the array top level.

Parameters:
- ARRAY_SIZE, 8, array dimension N; equals the skew buffer depth count.
- K_WIDTH, 16, width of the inner-dimension length and index.
- ROW_IDX_W, $clog2(ARRAY_SIZE), width of the output row index.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  command strobe; sampled only in IDLE
- k_len  in  K_WIDTH  inner dimension K; latched when start is accepted
- abort  in  1  synchronous cancel; returns the block to IDLE from any state
- busy  out  1  high in every state except IDLE
- acc_clear  out  1  one-cycle PE accumulator clear
- skew_en  out  1  enable to all skew buffers and PE registers
- feed_zero  out  1  operand muxes select zero instead of memory data
- feed_idx  out  K_WIDTH  operand read index k during LOAD
- out_valid  out  1  result row available
- out_row  out  ROW_IDX_W  index of the row being presented
- out_ready  in  1  consumer accepts the row
- done  out  1  one-cycle pulse after the final row handshake

Behaviour:
- All outputs are registered. Reset forces state=IDLE, all outputs 0 and all counters 0.
- Reset mid-operation aborts immediately; no partial done is produced.
- States: IDLE, CLEAR, LOAD, FLUSH, OUTPUT.
- IDLE:
  - start=1 latches k_len; next state is CLEAR.
  - start while busy is ignored; it is neither queued nor latched.
- CLEAR: acc_clear=1 for exactly one cycle; skew_en=1 and feed_zero=1 so the skew pipes are zero-filled.
  - Latched K>=1: next state LOAD, with the k counter at 0.
  - Latched K=0: next state OUTPUT, and all results read as zero.
- LOAD:
  - skew_en=1, feed_zero=0.
  - feed_idx=k, with k counting 0..K-1, one vector per cycle.
  - After k=K-1, next state FLUSH.
- FLUSH:
  - skew_en=1, feed_zero=1, for FLUSH_CYCLES = 2*ARRAY_SIZE-1 cycles.
  - These cycles cover the skew delay (N-1), propagation across the grid (N-1) and the PE register (1).
  - Then next state OUTPUT.
- OUTPUT:
  - skew_en=0, out_valid=1, out_row=r with r starting at 0.
  - r increments on out_valid&&out_ready.
  - out_row is held stable while out_ready=0.
  - After the handshake at r=N-1: next state IDLE, done=1 in that IDLE cycle, out_valid=0.
- feed_idx is 0 outside LOAD. skew_en is 0 in IDLE and OUTPUT.
- abort: has priority over all transitions. Next state is IDLE, with no done pulse and no acc_clear.
- start in the same cycle as abort while in IDLE: abort wins and start is dropped.
- A start arriving in the same cycle as done (state IDLE) is accepted.
- k counter width is K_WIDTH. The maximum K is 2^K_WIDTH-1, with no wrap during LOAD.

Decomposition:
- Package systolic_pkg:
  - state_t enum {IDLE, CLEAR, LOAD, FLUSH, OUTPUT};
  - function flush_cycles(N) = 2*N-1;
  - shared ARRAY_SIZE and K_WIDTH defaults used by the skew buffer and PE modules.
- One FSM module with three counters (k, flush, row).
- No sub-module is required; the counters are inline.

Test Plan (ARRAY_SIZE=4, so FLUSH_CYCLES=7):
- start with K=3 at cycle 0, out_ready=1:
  - CLEAR and acc_clear at cycle 1;
  - LOAD cycles 2-4 with feed_idx 0,1,2;
  - FLUSH cycles 5-11 with feed_zero=1;
  - out_valid cycles 12-15 with rows 0-3;
  - done=1 at cycle 16, busy=0.
- Same K=3 run with out_ready toggling 1,0,1,0:
  - each row is held until its handshake;
  - out_row never skips;
  - done comes exactly 1 cycle after the row-3 handshake.
- start with K=0: CLEAR at cycle 1, OUTPUT from cycle 2, no LOAD or FLUSH cycles, feed_idx stays 0.
- abort during FLUSH cycle 8 (K=3 run):
  - IDLE at cycle 9, all outputs 0, no done;
  - a new start at cycle 9 begins a clean run.
- start pulses at cycles 3 and 10 during a busy run: ignored, and the run timing is identical to the first scenario.
- rst asserted asynchronously mid-LOAD: outputs go to 0 immediately, with no clock edge required; after release, state is IDLE and busy=0.
